// File: rtl/store_pkg.sv
// Shared definitions for the M-stage store buffer: store op codes, the
// exception code raised on misaligned stores, and the FIFO entry layout.
package store_pkg;

    localparam logic [2:0] OP_SW = 3'b001;
    localparam logic [2:0] OP_SH = 3'b100;
    localparam logic [2:0] OP_SB = 3'b010;

    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam int STORE_DEPTH = 2;

    typedef struct packed {
        logic [29:0] addr_hi;
        logic [3:0]  byteen;
        logic [31:0] wdata;
    } store_entry_t;

endpackage

// File: rtl/store_align.sv
// Request-side store formatter: maps op / low address bits / register data
// onto word-bus byte enables and lane-replicated write data.
module store_align
    import store_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  a,
    input  logic [31:0] d,
    output logic [3:0]  byteen,
    output logic [31:0] wdata,
    output logic        legal,
    output logic        misaligned
);

    always_comb begin
        byteen     = 4'b0000;
        wdata      = 32'h0000_0000;
        legal      = 1'b0;
        misaligned = 1'b0;
        case (op)
            OP_SW: begin
                byteen     = 4'b1111;
                wdata      = d;
                legal      = 1'b1;
                misaligned = (a != 2'b00);
            end
            OP_SH: begin
                // Only A[1] selects the half; A[0] is dropped unless trapped.
                byteen     = a[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{d[15:0]}};
                legal      = 1'b1;
                misaligned = a[0];
            end
            OP_SB: begin
                byteen = 4'b0001 << a;
                wdata  = {4{d[7:0]}};
                legal  = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Two-entry store FIFO between the M stage and the data bus.
// Define STORE_ALIGN_CHECK_EN to trap misaligned sh/sw via exc_ades.
module store_buffer
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        m_data_valid,
    input  logic        m_data_ready,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic        store_pending,
    output logic        exc_ades
);

    store_entry_t mem [STORE_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    logic [3:0]   fmt_byteen;
    logic [31:0]  fmt_wdata;
    logic         op_legal;
    logic         misaligned;
    logic         push;
    logic         pop;
    store_entry_t head;

    store_align u_align (
        .op         (req_op),
        .a          (req_addr[1:0]),
        .d          (req_wdata),
        .byteen     (fmt_byteen),
        .wdata      (fmt_wdata),
        .legal      (op_legal),
        .misaligned (misaligned)
    );

`ifdef STORE_ALIGN_CHECK_EN
    assign exc_ades = req_valid && misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign exc_ades          = 1'b0;
`endif

    // No bypass at full: a same-cycle pop does not open a slot.
    assign req_ready     = (count != 2'd2);
    assign push          = req_valid && req_ready && op_legal && !exc_ades;
    assign m_data_valid  = (count != 2'd0);
    assign pop           = m_data_valid && m_data_ready;
    assign store_pending = (count != 2'd0);

    assign head          = mem[rd_ptr];
    assign m_data_addr   = m_data_valid ? {head.addr_hi, 2'b00} : 32'h0000_0000;
    assign m_data_wdata  = m_data_valid ? head.wdata : 32'h0000_0000;
    assign m_data_byteen = m_data_valid ? head.byteen : 4'b0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < STORE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{addr_hi: req_addr[31:2], byteen: fmt_byteen, wdata: fmt_wdata};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        m_data_valid;
    logic        m_data_ready;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic        store_pending;
    logic        exc_ades;

    int checks   = 0;
    int failures = 0;

    // Model entry: {addr[31:0], byteen[3:0], wdata[31:0]}
    logic [67:0] q [$];

    always #5 clk = ~clk;

    store_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .m_data_valid  (m_data_valid),
        .m_data_ready  (m_data_ready),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .store_pending (store_pending),
        .exc_ades      (exc_ades)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_sw(input logic [2:0] op); return op == 3'b001; endfunction
    function automatic bit is_sh(input logic [2:0] op); return op == 3'b100; endfunction
    function automatic bit is_sb(input logic [2:0] op); return op == 3'b010; endfunction

    function automatic bit model_exc(input logic v, input logic [2:0] op, input logic [31:0] addr);
`ifdef STORE_ALIGN_CHECK_EN
        int a = int'(addr[1:0]);
        return v && ((is_sh(op) && (a % 2 != 0)) || (is_sw(op) && a != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [67:0] model_fmt(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] d);
        int          a = int'(addr[1:0]);
        logic [3:0]  be = 4'b0000;
        logic [31:0] wd = 32'h0;
        for (int i = 0; i < 4; i++) begin
            be[i] = is_sw(op) || (is_sh(op) && (i / 2 == a / 2)) || (is_sb(op) && i == a);
            if (is_sw(op))      wd[8*i +: 8] = d[8*i +: 8];
            else if (is_sh(op)) wd[8*i +: 8] = d[8*(i % 2) +: 8];
            else                wd[8*i +: 8] = d[7:0];
        end
        return {addr[31:2], 2'b00, be, wd};
    endfunction

    // Compare all outputs against the model, then advance model and clock.
    task automatic step();
        logic [67:0] h;
        bit          mv;
        #3;
        mv = (q.size() != 0);
        h  = mv ? q[0] : 68'h0;
        check("req_ready", 32'(req_ready), 32'(q.size() != 2));
        check("m_data_valid", 32'(m_data_valid), 32'(mv));
        check("store_pending", 32'(store_pending), 32'(mv));
        check("exc_ades", 32'(exc_ades), 32'(model_exc(req_valid, req_op, req_addr)));
        if (mv) begin
            check("m_data_addr", m_data_addr, h[67:36]);
            check("m_data_byteen", 32'(m_data_byteen), 32'(h[35:32]));
            check("m_data_wdata", m_data_wdata, h[31:0]);
        end
        if (reset) begin
            q.delete();
        end else begin
            bit do_push;
            do_push = req_valid && (q.size() != 2) && (is_sw(req_op) || is_sh(req_op) || is_sb(req_op))
                      && !model_exc(req_valid, req_op, req_addr);
            if (mv && m_data_ready) void'(q.pop_front());
            if (do_push) q.push_back(model_fmt(req_op, req_addr, req_wdata));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] d);
        req_valid = v;
        req_op    = op;
        req_addr  = addr;
        req_wdata = d;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wd);
        check({tag, "_valid"}, 32'(m_data_valid), 32'd1);
        check({tag, "_addr"}, m_data_addr, addr);
        check({tag, "_byteen"}, 32'(m_data_byteen), 32'(be));
        check({tag, "_wdata"}, m_data_wdata, wd);
    endtask

    initial begin
        reset        = 1'b1;
        m_data_ready = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        step();
        check("rst_valid", 32'(m_data_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_addr", m_data_addr, 32'h0);
        check("rst_byteen", 32'(m_data_byteen), 32'h0);
        check("rst_wdata", m_data_wdata, 32'h0);
        check("rst_pending", 32'(store_pending), 32'd0);
        reset = 1'b0;

        // sb to the top byte lane
        drive(1'b1, 3'b010, 32'h0000_1003, 32'h0000_00AB);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        expect_head("sb", 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
        step();
        check("sb_drained", 32'(store_pending), 32'd0);

        drive(1'b1, 3'b100, 32'h0000_2002, 32'h0000_1234);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        expect_head("sh", 32'h0000_2000, 4'b1100, 32'h1234_1234);
        step();
        drive(1'b1, 3'b001, 32'h0000_2004, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        expect_head("sw", 32'h0000_2004, 4'b1111, 32'hDEAD_BEEF);
        step();

        // Bus stalled: third store back-pressured until a slot frees
        m_data_ready = 1'b0;
        drive(1'b1, 3'b001, 32'h0000_4000, 32'h1111_1111);
        step();
        drive(1'b1, 3'b001, 32'h0000_4004, 32'h2222_2222);
        step();
        drive(1'b1, 3'b001, 32'h0000_4008, 32'h3333_3333);
        check("full_ready", 32'(req_ready), 32'd0);
        step();
        expect_head("stall_head", 32'h0000_4000, 4'b1111, 32'h1111_1111);
        step();
        m_data_ready = 1'b1;
        step();
        check("third_held_ready", 32'(req_ready), 32'd1);
        expect_head("second_head", 32'h0000_4004, 4'b1111, 32'h2222_2222);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        expect_head("third_head", 32'h0000_4008, 4'b1111, 32'h3333_3333);
        step();
        step();

        // Count 1 with simultaneous push and pop
        m_data_ready = 1'b0;
        drive(1'b1, 3'b010, 32'h0000_5001, 32'h0000_0055);
        step();
        m_data_ready = 1'b1;
        drive(1'b1, 3'b100, 32'h0000_6000, 32'h0000_BEEF);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("pp_pending", 32'(store_pending), 32'd1);
        expect_head("pp_head", 32'h0000_6000, 4'b0011, 32'hBEEF_BEEF);
        step();

        // Misaligned sw
        drive(1'b1, 3'b001, 32'h0000_3001, 32'hCAFE_F00D);
        #2;
`ifdef STORE_ALIGN_CHECK_EN
        check("ades_raised", 32'(exc_ades), 32'd1);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        check("ades_no_write", 32'(m_data_valid), 32'd0);
`else
        check("ades_tied", 32'(exc_ades), 32'd0);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        expect_head("mis_sw", 32'h0000_3000, 4'b1111, 32'hCAFE_F00D);
`endif
        step();

        // Reset with two entries pending
        m_data_ready = 1'b0;
        drive(1'b1, 3'b001, 32'h0000_7000, 32'h7);
        step();
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", 32'(m_data_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_pending", 32'(store_pending), 32'd0);

        // Randomized traffic including illegal ops and occasional reset
        for (int n = 0; n < 600; n++) begin
            logic [2:0] op;
            case ($urandom_range(0, 4))
                0:       op = 3'b001;
                1:       op = 3'b100;
                2:       op = 3'b010;
                3:       op = 3'($urandom_range(0, 7));
                default: op = 3'b010;
            endcase
            drive(1'($urandom_range(0, 1)), op, $urandom, $urandom);
            m_data_ready = ($urandom_range(0, 3) != 0);
            reset        = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Memory-stage store unit for the P7 MIPS CPU; the write-side counterpart of the load extender. It accepts `sw`/`sh`/`sb` requests from the M stage, converts each into a word-aligned bus write with byte enables and lane-replicated data, and holds them in a 2-entry FIFO. Entries drain to the data bus through a valid/ready handshake. The block stalls the pipeline when full and reports pending stores so the hazard unit can hold younger loads.

## Interface
- `DEPTH`, 2, FIFO entries (fixed at 2; count width 2 bits)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  M-stage store request present
- `req_op`  in  3  store type: 3'b001 sw, 3'b100 sh, 3'b010 sb; any other value means no store
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  register data; low byte/halfword used for sb/sh
- `req_ready`  out  1  FIFO can accept; pipeline stalls when `req_valid && !req_ready`
- `m_data_valid`  out  1  head entry presented to the bus
- `m_data_ready`  in  1  bus accepts head entry this cycle
- `m_data_addr`  out  32  head address, bits [1:0] forced to 0
- `m_data_wdata`  out  32  head lane-replicated data
- `m_data_byteen`  out  4  head byte enables
- `store_pending`  out  1  count != 0
- `exc_ades`  out  1  misaligned-store exception (only with macro)

## Operation
- Push when `req_valid && req_ready && op legal && !exc_ades`. Pop when `m_data_valid && m_data_ready`.
- Formatting, with A = `req_addr[1:0]`:
  - sb: byteen = 4'b0001 << A; wdata = {4{d[7:0]}}.
  - sh: byteen = A[1] ? 4'b1100 : 4'b0011; wdata = {2{d[15:0]}}.
  - sw: byteen = 4'b1111; wdata = d.
- Entry stores {addr[31:2], byteen, wdata}. Head is presented combinationally from the read pointer.
- `req_ready` = (count != 2). There is no bypass at full: a pop in the same cycle does not free space for a push.
- Count 1, simultaneous push and pop: count stays 1, and the new entry becomes head next cycle.
- Count 0, push: `m_data_valid` rises the next cycle (no same-cycle bypass).
- Pointers are 1 bit each and wrap 1→0.
- Strict FIFO order. Entries never merge.
- `m_data_valid` may not drop while the head is unaccepted; `m_data_*` stay stable until popped.
- Reset mid-operation discards all entries.
- Reset values: count 0, pointers 0, `m_data_valid` 0, `m_data_addr`/`m_data_wdata`/`m_data_byteen` 0, `store_pending` 0, `req_ready` 1, `exc_ades` 0.

## Timing
- Enqueue-to-bus latency is 1 cycle when empty. With one entry ahead, it is 1 cycle plus that entry's drain time.
- Throughput is 1 store per cycle when `m_data_ready` is held high (count alternates 0/1 or stays at 1).
- `exc_ades` is combinational in the request cycle, independent of `req_ready`.

## Configuration
- `STORE_ALIGN_CHECK_EN` defined:
  - `exc_ades` = `req_valid && ((sh && A[0]) || (sw && A != 0))`.
  - A faulting request is not pushed and produces no bus write.
  - `store_pending`, count and pointers are unaffected.
- Undefined:
  - `exc_ades` is tied to 0.
  - Misaligned requests are pushed with the ignored low bits dropped: sh uses A[1] only; sw ignores A.

## Structure
- Package `store_pkg`:
  - op codes `OP_SW`/`OP_SH`/`OP_SB`
  - `EXC_ADES` = 5'd5
  - `STORE_DEPTH` = 2
  - entry struct {addr_hi[29:0], byteen[3:0], wdata[31:0]}
- Sub-module `store_align`: combinational formatter (op, A, d → byteen, wdata, misaligned), instantiated once on the request side.

## Test plan
- Reset, then sb addr 0x0000_1003 data 0x0000_00AB with ready=1 → next cycle valid, addr 0x0000_1000, byteen 4'b1000, wdata 0xABABABAB; popped, count returns to 0.
- sh addr 0x2002 data 0x1234 → byteen 4'b1100, wdata 0x12341234. sw addr 0x2004 → byteen 4'b1111, addr 0x2004.
- `m_data_ready`=0, three sw requests on consecutive cycles → the first two are accepted, then `req_ready`=0. The third is held until ready=1 frees a slot and is accepted one cycle after the first pop; bus order matches issue order and head outputs stay stable during the stall.
- Count 1 with simultaneous push and pop → count stays 1, `store_pending`=1, and the new head appears next cycle.
- With `STORE_ALIGN_CHECK_EN`, sw addr 0x3001 → `exc_ades`=1 and no bus write. Without it → one write to 0x3000 with byteen 4'b1111.
- Reset asserted while two entries are pending → next cycle `m_data_valid`=0, `req_ready`=1, `store_pending`=0.
